interval_trainer_fsm: RTL and testbench

- Parametrised workout/rest interval sequencer; next generation of the single-profile trainer FSM.
- Sequences a target number of rounds. Each round is a work phase followed by a rest phase.
- Exposes round count, remaining phase time, phase code and a buzzer event code.
- Adds over the previous generation:
  - configurable work/rest durations and counter widths;
  - a built-in tick prescaler;
  - pause/resume;
  - one-cycle buzzer pulses and a done pulse.
- Target round count arrives from the upstream calculator (TCalc-style) on Tgt.

---
 rtl/interval_trainer_fsm.sv | 180 ++++++++++++++++++
 tb/tb_interval_trainer_fsm.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/interval_trainer_fsm.sv
// Work/rest interval sequencer: counts rounds of WORK then REST phases with a
// tick prescaler, pause/resume, skip, and one-cycle buzzer/done pulses.
module interval_trainer_fsm #(
  parameter int CNT_W     = 9,
  parameter int TI_W      = 6,
  parameter int WORK_TIME = 45,
  parameter int REST_TIME = 15,
  parameter int TICK_DIV  = 1
) (
  input  logic             Clk,
  input  logic             Re,
  input  logic             St,
  input  logic             Ps,
  input  logic             Sk,
  input  logic [CNT_W-1:0] Tgt,
  output logic [1:0]       Bu,
  output logic             Dn,
  output logic [CNT_W-1:0] Cn,
  output logic [TI_W-1:0]  Ti,
  output logic [1:0]       Ph
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WORK  = 2'b01,
    S_REST  = 2'b10,
    S_PAUSE = 2'b11
  } state_t;

  localparam int PC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PC_W-1:0]  PC_ZERO = {PC_W{1'b0}};
  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
  localparam logic [PC_W-1:0]  PC_LAST = PC_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CN_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CN_ONE  = CNT_W'(1);
  localparam logic [TI_W-1:0]  TI_ZERO = {TI_W{1'b0}};
  localparam logic [TI_W-1:0]  TI_ONE  = TI_W'(1);
  localparam logic [TI_W-1:0]  WORK_LD = TI_W'(WORK_TIME);
  localparam logic [TI_W-1:0]  REST_LD = TI_W'(REST_TIME);

  if (WORK_TIME < 0 || WORK_TIME >= (1 << TI_W)) begin : g_work_chk
    $error("WORK_TIME does not fit in TI_W bits");
  end
  if (REST_TIME < 0 || REST_TIME >= (1 << TI_W)) begin : g_rest_chk
    $error("REST_TIME does not fit in TI_W bits");
  end
  if (TICK_DIV < 1) begin : g_div_chk
    $error("TICK_DIV must be 1 or more");
  end

  state_t           state_r, state_nx_s, saved_r, saved_nx_s;
  logic [CNT_W-1:0] tgt_r, tgt_nx_s, cn_r, cn_nx_s;
  logic [TI_W-1:0]  ti_r, ti_nx_s;
  logic [PC_W-1:0]  pc_r, pc_nx_s;
  logic [1:0]       bu_r, bu_nx_s;
  logic             dn_r, dn_nx_s;
  logic             tick_s, last_s, start_ok_s, ti_zero_s;

  assign tick_s     = (pc_r == PC_LAST);
  assign last_s     = (cn_r == tgt_r);
  assign start_ok_s = St && (Tgt != CN_ZERO);
  assign ti_zero_s  = (ti_r == TI_ZERO);

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Re) begin
      state_r <= S_IDLE;
      saved_r <= S_IDLE;
      tgt_r   <= CN_ZERO;
      cn_r    <= CN_ZERO;
      ti_r    <= TI_ZERO;
      pc_r    <= PC_ZERO;
      bu_r    <= 2'b00;
      dn_r    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      saved_r <= saved_nx_s;
      tgt_r   <= tgt_nx_s;
      cn_r    <= cn_nx_s;
      ti_r    <= ti_nx_s;
      pc_r    <= pc_nx_s;
      bu_r    <= bu_nx_s;
      dn_r    <= dn_nx_s;
    end
  end

  // Next-state selection; skip outranks pause, which outranks the tick
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_ok_s) state_nx_s = S_WORK;
        else            state_nx_s = S_IDLE;
      end
      S_WORK, S_REST: begin
        if (Sk)                       state_nx_s = last_s ? S_IDLE : S_WORK;
        else if (Ps)                  state_nx_s = S_PAUSE;
        else if (tick_s && ti_zero_s) begin
          if (state_r == S_WORK)      state_nx_s = S_REST;
          else                        state_nx_s = last_s ? S_IDLE : S_WORK;
        end else                      state_nx_s = state_r;
      end
      S_PAUSE: begin
        if (Ps) state_nx_s = saved_r;
        else    state_nx_s = S_PAUSE;
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Next values of counters, timer, prescaler and event pulses
  always_comb begin
    saved_nx_s = saved_r;
    tgt_nx_s   = tgt_r;
    cn_nx_s    = cn_r;
    ti_nx_s    = ti_r;
    pc_nx_s    = pc_r;
    bu_nx_s    = 2'b00;
    dn_nx_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        ti_nx_s = TI_ZERO;
        pc_nx_s = PC_ZERO;
        if (start_ok_s) begin
          tgt_nx_s = Tgt;
          cn_nx_s  = CN_ONE;
          ti_nx_s  = WORK_LD;
        end else begin
          tgt_nx_s = tgt_r;
        end
      end
      S_WORK, S_REST: begin
        if (Sk) begin
          pc_nx_s = PC_ZERO;
          if (last_s) begin
            bu_nx_s = 2'b11;
            dn_nx_s = 1'b1;
            ti_nx_s = TI_ZERO;
          end else begin
            cn_nx_s = cn_r + CN_ONE;
            ti_nx_s = WORK_LD;
            bu_nx_s = 2'b10;
          end
        end else if (Ps) begin
          saved_nx_s = state_r;
        end else if (tick_s) begin
          pc_nx_s = PC_ZERO;
          if (!ti_zero_s) begin
            ti_nx_s = ti_r - TI_ONE;
          end else if (state_r == S_WORK) begin
            ti_nx_s = REST_LD;
          end else if (last_s) begin
            bu_nx_s = 2'b11;
            dn_nx_s = 1'b1;
            ti_nx_s = TI_ZERO;
          end else begin
            cn_nx_s = cn_r + CN_ONE;
            ti_nx_s = WORK_LD;
            bu_nx_s = 2'b01;
          end
        end else begin
          pc_nx_s = pc_r + PC_ONE;
        end
      end
      S_PAUSE: begin
        pc_nx_s = pc_r;
      end
      default: begin
        pc_nx_s = PC_ZERO;
      end
    endcase
  end

  assign Bu = bu_r;
  assign Dn = dn_r;
  assign Cn = cn_r;
  assign Ti = ti_r;
  assign Ph = state_r;

endmodule

// File: tb/tb_interval_trainer_fsm.sv
// Scoreboard bench: stimulus queues cycle-stamped expected outputs, a negedge
// monitor compares them and flags any buzzer pulse that was not expected.
module tb_interval_trainer_fsm;

  localparam logic [1:0] P_IDLE  = 2'b00;
  localparam logic [1:0] P_WORK  = 2'b01;
  localparam logic [1:0] P_REST  = 2'b10;
  localparam logic [1:0] P_PAUSE = 2'b11;

  logic       Clk = 1'b0;
  logic       re_a = 1'b0, st_a = 1'b0, ps_a = 1'b0, sk_a = 1'b0;
  logic       re_b = 1'b0, st_b = 1'b0, ps_b = 1'b0, sk_b = 1'b0;
  logic [8:0] tgt_a = 9'd0, tgt_b = 9'd0;
  logic [1:0] bu_a, bu_b, ph_a, ph_b;
  logic       dn_a, dn_b;
  logic [8:0] cn_a, cn_b;
  logic [5:0] ti_a, ti_b;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         cyc;
    bit         inst;
    logic [1:0] bu;
    logic       dn;
    logic [8:0] cn;
    logic [5:0] ti;
    logic [1:0] ph;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  interval_trainer_fsm #(.CNT_W(9), .TI_W(6), .WORK_TIME(3), .REST_TIME(2), .TICK_DIV(4)) dut_a (
    .Clk(Clk), .Re(re_a), .St(st_a), .Ps(ps_a), .Sk(sk_a), .Tgt(tgt_a),
    .Bu(bu_a), .Dn(dn_a), .Cn(cn_a), .Ti(ti_a), .Ph(ph_a)
  );

  interval_trainer_fsm #(.CNT_W(9), .TI_W(6), .WORK_TIME(0), .REST_TIME(0), .TICK_DIV(1)) dut_b (
    .Clk(Clk), .Re(re_b), .St(st_b), .Ps(ps_b), .Sk(sk_b), .Tgt(tgt_b),
    .Bu(bu_b), .Dn(dn_b), .Cn(cn_b), .Ti(ti_b), .Ph(ph_b)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic expect_at(input int dly, input bit inst, input logic [1:0] bu, input logic dn,
                           input logic [8:0] cn, input logic [5:0] ti, input logic [1:0] ph,
                           input string name);
    exp_t e;
    e.cyc = cyc + dly; e.inst = inst; e.bu = bu; e.dn = dn;
    e.cn = cn; e.ti = ti; e.ph = ph; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic check(input exp_t e);
    logic [1:0] bu, ph;
    logic       dn;
    logic [8:0] cn;
    logic [5:0] ti;
    if (e.inst) begin bu = bu_b; dn = dn_b; cn = cn_b; ti = ti_b; ph = ph_b; end
    else        begin bu = bu_a; dn = dn_a; cn = cn_a; ti = ti_a; ph = ph_a; end
    n_cmp++;
    if ({bu, dn, cn, ti, ph} !== {e.bu, e.dn, e.cn, e.ti, e.ph}) begin
      n_bad++;
      $display("FAIL %s (dut %0d, cycle %0d): got bu=%b dn=%b cn=%0d ti=%0d ph=%b, want bu=%b dn=%b cn=%0d ti=%0d ph=%b",
               e.name, e.inst, cyc, bu, dn, cn, ti, ph, e.bu, e.dn, e.cn, e.ti, e.ph);
    end
  endtask

  // Monitor: compare due expectations, then police unexpected buzzer pulses
  always @(negedge Clk) begin : mon
    exp_t keep[$];
    bit   seen_a, seen_b;
    keep.delete();
    seen_a = 1'b0;
    seen_b = 1'b0;
    foreach (exp_q[i]) begin
      if (exp_q[i].cyc == cyc) begin
        check(exp_q[i]);
        if (exp_q[i].inst) seen_b = 1'b1;
        else               seen_a = 1'b1;
      end else if (exp_q[i].cyc < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL %s: expectation for cycle %0d was never checked", exp_q[i].name, exp_q[i].cyc);
      end else begin
        keep.push_back(exp_q[i]);
      end
    end
    exp_q = keep;
    if (!seen_a && (bu_a !== 2'b00 || dn_a !== 1'b0)) begin
      n_cmp++; n_bad++;
      $display("FAIL spurious_event_a (cycle %0d): got bu=%b dn=%b, want bu=00 dn=0", cyc, bu_a, dn_a);
    end
    if (!seen_b && (bu_b !== 2'b00 || dn_b !== 1'b0)) begin
      n_cmp++; n_bad++;
      $display("FAIL spurious_event_b (cycle %0d): got bu=%b dn=%b, want bu=00 dn=0", cyc, bu_b, dn_b);
    end
  end

  initial begin
    step(1);
    // Reset state of both instances
    expect_at(1, 1'b0, 2'b00, 1'b0, 9'd0, 6'd0, P_IDLE, "reset_a");
    expect_at(1, 1'b1, 2'b00, 1'b0, 9'd0, 6'd0, P_IDLE, "reset_b");
    step(2);
    re_a = 1'b1; re_b = 1'b1;
    step(1);

    // Full two-round session; Tgt changes after start must not matter
    tgt_a = 9'd2; st_a = 1'b1;
    expect_at(1,  1'b0, 2'b00, 1'b0, 9'd1, 6'd3, P_WORK, "start");
    expect_at(16, 1'b0, 2'b00, 1'b0, 9'd1, 6'd0, P_WORK, "work_last_tick");
    expect_at(17, 1'b0, 2'b00, 1'b0, 9'd1, 6'd2, P_REST, "rest_entry");
    expect_at(29, 1'b0, 2'b01, 1'b0, 9'd2, 6'd3, P_WORK, "next_round");
    expect_at(57, 1'b0, 2'b11, 1'b1, 9'd2, 6'd0, P_IDLE, "session_done");
    expect_at(58, 1'b0, 2'b00, 1'b0, 9'd2, 6'd0, P_IDLE, "idle_keeps_cn");
    step(1); st_a = 1'b0; tgt_a = 9'd7;
    step(60);

    // Skip advances the round, then skip on the last round finishes
    tgt_a = 9'd2; st_a = 1'b1;
    expect_at(5,  1'b0, 2'b10, 1'b0, 9'd2, 6'd3, P_WORK, "skip_round");
    expect_at(6,  1'b0, 2'b00, 1'b0, 9'd2, 6'd3, P_WORK, "skip_pulse_end");
    expect_at(8,  1'b0, 2'b00, 1'b0, 9'd2, 6'd3, P_WORK, "skip_pc_cleared");
    expect_at(9,  1'b0, 2'b11, 1'b1, 9'd2, 6'd0, P_IDLE, "skip_finish");
    expect_at(10, 1'b0, 2'b00, 1'b0, 9'd2, 6'd0, P_IDLE, "skip_idle");
    step(1); st_a = 1'b0;
    step(3); sk_a = 1'b1;
    step(1); sk_a = 1'b0;
    step(3); sk_a = 1'b1;
    step(1); sk_a = 1'b0;
    step(3);

    // Pause at Ti=2/pc=1, ignore Sk and St for 20 cycles, then resume
    tgt_a = 9'd2; st_a = 1'b1;
    expect_at(6,  1'b0, 2'b00, 1'b0, 9'd1, 6'd2, P_WORK,  "pre_pause");
    expect_at(7,  1'b0, 2'b00, 1'b0, 9'd1, 6'd2, P_PAUSE, "pause_entry");
    expect_at(11, 1'b0, 2'b00, 1'b0, 9'd1, 6'd2, P_PAUSE, "pause_ignores_sk");
    expect_at(26, 1'b0, 2'b00, 1'b0, 9'd1, 6'd2, P_PAUSE, "pause_frozen");
    expect_at(27, 1'b0, 2'b00, 1'b0, 9'd1, 6'd2, P_WORK,  "resume");
    expect_at(29, 1'b0, 2'b00, 1'b0, 9'd1, 6'd2, P_WORK,  "resume_pc_kept");
    expect_at(30, 1'b0, 2'b00, 1'b0, 9'd1, 6'd1, P_WORK,  "resume_tick");
    step(1); st_a = 1'b0;
    step(5); ps_a = 1'b1;
    step(1); ps_a = 1'b0;
    step(3); sk_a = 1'b1; st_a = 1'b1;
    step(1); sk_a = 1'b0; st_a = 1'b0;
    step(15); ps_a = 1'b1;
    step(1); ps_a = 1'b0;
    step(5);
    re_a = 1'b0;
    expect_at(1, 1'b0, 2'b00, 1'b0, 9'd0, 6'd0, P_IDLE, "reset_in_work");
    step(1); re_a = 1'b1;

    // Zero target is ignored
    tgt_a = 9'd0; st_a = 1'b1;
    expect_at(1, 1'b0, 2'b00, 1'b0, 9'd0, 6'd0, P_IDLE, "tgt_zero");
    expect_at(2, 1'b0, 2'b00, 1'b0, 9'd0, 6'd0, P_IDLE, "tgt_zero_hold");
    step(1); st_a = 1'b0;
    step(2);

    // Reset in REST aborts silently; a fresh start begins at round 1
    tgt_a = 9'd2; st_a = 1'b1;
    expect_at(17, 1'b0, 2'b00, 1'b0, 9'd1, 6'd2, P_REST, "rest_before_reset");
    expect_at(21, 1'b0, 2'b00, 1'b0, 9'd1, 6'd1, P_REST, "rest_ti1");
    expect_at(22, 1'b0, 2'b00, 1'b0, 9'd0, 6'd0, P_IDLE, "reset_in_rest");
    expect_at(23, 1'b0, 2'b00, 1'b0, 9'd1, 6'd3, P_WORK, "restart");
    step(1); st_a = 1'b0;
    step(20); re_a = 1'b0;
    step(1); re_a = 1'b1; st_a = 1'b1; tgt_a = 9'd3;
    step(1); st_a = 1'b0;
    step(2); re_a = 1'b0;
    step(2);

    // Minimal timing: one-tick phases, finish on the third cycle
    tgt_b = 9'd1; st_b = 1'b1;
    expect_at(1, 1'b1, 2'b00, 1'b0, 9'd1, 6'd0, P_WORK, "min_work");
    expect_at(2, 1'b1, 2'b00, 1'b0, 9'd1, 6'd0, P_REST, "min_rest");
    expect_at(3, 1'b1, 2'b11, 1'b1, 9'd1, 6'd0, P_IDLE, "min_done");
    expect_at(4, 1'b1, 2'b00, 1'b0, 9'd1, 6'd0, P_IDLE, "min_idle");
    step(1); st_b = 1'b0;
    step(4);

    // Simultaneous skip and pause: skip wins
    tgt_b = 9'd2; st_b = 1'b1;
    expect_at(1, 1'b1, 2'b00, 1'b0, 9'd1, 6'd0, P_WORK, "sp_start");
    expect_at(2, 1'b1, 2'b10, 1'b0, 9'd2, 6'd0, P_WORK, "sp_skip_wins");
    expect_at(3, 1'b1, 2'b00, 1'b0, 9'd2, 6'd0, P_REST, "sp_no_pause");
    expect_at(4, 1'b1, 2'b11, 1'b1, 9'd2, 6'd0, P_IDLE, "sp_done");
    step(1); st_b = 1'b0; sk_b = 1'b1; ps_b = 1'b1;
    step(1); sk_b = 1'b0; ps_b = 1'b0;
    step(5);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_expectations: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
